// File: rtl/mips_multicycle_ctrl.sv
// Multicycle control FSM for the 8-bit MIPS-subset datapath.
// Outputs are a Moore decode of the state, gated by mem_ready/zero where a state needs them.
module mips_multicycle_ctrl (
  input  logic       ph1,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       memread,
  output logic       memwrite,
  output logic       iord,
  output logic [3:0] irwrite,
  output logic       pcen,
  output logic [1:0] pcsource,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       instr_done,
  output logic       illegal_op
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH1  = 4'd0,
    S_FETCH2  = 4'd1,
    S_FETCH3  = 4'd2,
    S_FETCH4  = 4'd3,
    S_DECODE  = 4'd4,
    S_MEMADR  = 4'd5,
    S_LBRD    = 4'd6,
    S_LBWR    = 4'd7,
    S_SBWR    = 4'd8,
    S_RTYPEEX = 4'd9,
    S_RTYPEWR = 4'd10,
    S_BEQEX   = 4'd11,
    S_JEX     = 4'd12,
    S_ADDIEX  = 4'd13,
    S_ADDIWR  = 4'd14
  } state_e;

  state_e state_q, state_d;
  logic   pcwrite;
  logic   branch;

  // State register; reset abandons any partial instruction.
  always_ff @(posedge ph1) begin
    if (reset) state_q <= S_FETCH1;
    else       state_q <= state_d;
  end

  // Next-state and output decode.
  always_comb begin
    state_d    = S_FETCH1;
    memread    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 4'b0000;
    pcsource   = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    pcen       = 1'b0;

    unique case (state_q)
      S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        // Byte latch and PC increment happen only on the cycle memory delivers.
        if (mem_ready) begin
          pcwrite = 1'b1;
          unique case (state_q)
            S_FETCH1: begin irwrite = 4'b0001; state_d = S_FETCH2; end
            S_FETCH2: begin irwrite = 4'b0010; state_d = S_FETCH3; end
            S_FETCH3: begin irwrite = 4'b0100; state_d = S_FETCH4; end
            default:  begin irwrite = 4'b1000; state_d = S_DECODE; end
          endcase
        end else begin
          state_d = state_q;
        end
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        unique case (op)
          OP_LB, OP_SB: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_J:         state_d = S_JEX;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            state_d    = S_FETCH1;
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (op == OP_LB)      state_d = S_LBRD;
        else if (op == OP_SB) state_d = S_SBWR;
        else                  state_d = S_FETCH1;
      end
      S_LBRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        state_d = mem_ready ? S_LBWR : S_LBRD;
      end
      S_LBWR: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        instr_done = 1'b1;
      end
      S_SBWR: begin
        memwrite   = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
        state_d    = mem_ready ? S_FETCH1 : S_SBWR;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = S_RTYPEWR;
      end
      S_RTYPEWR: begin
        regwrite   = 1'b1;
        regdst     = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQEX: begin
        alusrca    = 1'b1;
        aluop      = 2'b01;
        branch     = 1'b1;
        pcsource   = 2'b01;
        instr_done = 1'b1;
      end
      S_JEX: begin
        pcwrite    = 1'b1;
        pcsource   = 2'b10;
        instr_done = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWR;
      end
      S_ADDIWR: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      default: state_d = S_FETCH1;
    endcase

    pcen = pcwrite | (branch & zero);

    // Reset masks every enable so no architectural state can change.
    if (reset) begin
      memread    = 1'b0;
      memwrite   = 1'b0;
      iord       = 1'b0;
      irwrite    = 4'b0000;
      pcen       = 1'b0;
      pcsource   = 2'b00;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      aluop      = 2'b00;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: instructions are expanded into expected per-cycle
// control words from the instruction-level rules, then replayed against the DUT.
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       iord;
    logic [3:0] irwrite;
    logic       pcen;
    logic [1:0] pcsource;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       instr_done;
    logic       illegal_op;
  } outs_t;

  typedef struct {
    logic       mr;
    logic       z;
    logic [5:0] op;
    outs_t      e;
    int         ph;
  } step_t;

  logic       ph1 = 1'b0;
  logic       reset, zero, mem_ready;
  logic [5:0] op;
  logic       memread, memwrite, iord, pcen, alusrca, regdst, memtoreg;
  logic       regwrite, instr_done, illegal_op;
  logic [3:0] irwrite;
  logic [1:0] pcsource, alusrcb, aluop;
  outs_t      obs;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  step_t q[$];

  mips_multicycle_ctrl dut (
    .ph1(ph1), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .memread(memread), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
    .pcen(pcen), .pcsource(pcsource), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .instr_done(instr_done), .illegal_op(illegal_op)
  );

  always #5 ph1 = ~ph1;

  assign obs = {memread, memwrite, iord, irwrite, pcen, pcsource, alusrca,
                alusrcb, aluop, regdst, memtoreg, regwrite, instr_done, illegal_op};

  task automatic check(input outs_t exp, input int ph);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL ctrl ph%0d cyc%0d observed %h expected %h", ph, cyc, obs, exp);
    end
  endtask

  task automatic push(input logic mr, input logic z, input logic [5:0] o,
                      input outs_t e, input int ph);
    step_t s;
    s.mr = mr; s.z = z; s.op = o; s.e = e; s.ph = ph;
    q.push_back(s);
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // Expand one instruction: fs holds 2-bit stall counts per fetch byte, ms the data-access stalls.
  task automatic add_instr(input logic [5:0] o, input logic zv, input logic [7:0] fs,
                           input int ms);
    outs_t e;
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < int'(fs[2*k +: 2]); s++) begin
        e = '0; e.memread = 1'b1; e.alusrcb = 2'b01;
        push(1'b0, rb(), o, e, k);
      end
      e = '0; e.memread = 1'b1; e.alusrcb = 2'b01;
      e.irwrite = 4'(1 << k); e.pcen = 1'b1;
      push(1'b1, rb(), o, e, k);
    end
    e = '0; e.alusrcb = 2'b11;
    if (!(o inside {OP_RTYPE, OP_LB, OP_SB, OP_BEQ, OP_J, OP_ADDI})) begin
      e.illegal_op = 1'b1; e.instr_done = 1'b1;
      push(rb(), rb(), o, e, 4);
      return;
    end
    push(rb(), rb(), o, e, 4);
    case (o)
      OP_LB, OP_SB: begin
        e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10;
        push(rb(), rb(), o, e, 5);
        e = '0; e.iord = 1'b1;
        if (o == OP_LB) e.memread = 1'b1; else e.memwrite = 1'b1;
        for (int s = 0; s < ms; s++) push(1'b0, rb(), o, e, 6);
        if (o == OP_SB) e.instr_done = 1'b1;
        push(1'b1, rb(), o, e, 6);
        if (o == OP_LB) begin
          e = '0; e.regwrite = 1'b1; e.memtoreg = 1'b1; e.instr_done = 1'b1;
          push(rb(), rb(), o, e, 7);
        end
      end
      OP_RTYPE: begin
        e = '0; e.alusrca = 1'b1; e.aluop = 2'b10;
        push(rb(), rb(), o, e, 9);
        e = '0; e.regwrite = 1'b1; e.regdst = 1'b1; e.instr_done = 1'b1;
        push(rb(), rb(), o, e, 10);
      end
      OP_BEQ: begin
        e = '0; e.alusrca = 1'b1; e.aluop = 2'b01; e.pcsource = 2'b01;
        e.instr_done = 1'b1; e.pcen = zv;
        push(rb(), zv, o, e, 11);
      end
      OP_J: begin
        e = '0; e.pcen = 1'b1; e.pcsource = 2'b10; e.instr_done = 1'b1;
        push(rb(), rb(), o, e, 12);
      end
      default: begin
        e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10;
        push(rb(), rb(), o, e, 13);
        e = '0; e.regwrite = 1'b1; e.instr_done = 1'b1;
        push(rb(), rb(), o, e, 14);
      end
    endcase
  endtask

  // Replay queued steps down to keep entries: drive after posedge, check at negedge.
  task automatic run_to(input int keep);
    step_t s;
    while (q.size() > keep) begin
      s = q.pop_front();
      mem_ready = s.mr; zero = s.z; op = s.op;
      @(negedge ph1);
      check(s.e, s.ph);
      @(posedge ph1); #1;
      cyc++;
    end
  endtask

  // Latency with mem_ready high, counted as steps queued for a stall-free instruction.
  task automatic check_latency(input logic [5:0] o, input int want);
    int got;
    q.delete();
    add_instr(o, 1'b0, 8'h00, 0);
    got = q.size();
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL latency op%b observed %0d expected %0d", o, got, want);
    end
    run_to(0);
  endtask

  initial begin
    outs_t e;
    logic [5:0] o;
    int r;

    reset = 1'b1; mem_ready = 1'b1; zero = 1'b1; op = OP_J;
    @(posedge ph1); #1;
    for (int i = 0; i < 3; i++) begin
      mem_ready = rb(); zero = rb(); op = 6'($urandom);
      @(negedge ph1);
      check('0, 99);
      @(posedge ph1); #1;
    end
    reset = 1'b0;

    // Directed sequence following the plan.
    add_instr(OP_RTYPE, 1'b0, 8'h00, 0);
    add_instr(OP_LB,    1'b0, 8'h00, 3);
    add_instr(OP_BEQ,   1'b1, 8'h00, 0);
    add_instr(OP_BEQ,   1'b0, 8'h00, 0);
    add_instr(OP_ADDI,  1'b0, 8'b0000_1000, 0);
    add_instr(6'b111111, 1'b0, 8'h00, 0);
    add_instr(OP_SB,    1'b0, 8'h00, 2);
    add_instr(OP_J,     1'b0, 8'h00, 0);
    run_to(0);

    check_latency(OP_LB, 8);
    check_latency(OP_SB, 7);
    check_latency(OP_RTYPE, 7);
    check_latency(OP_ADDI, 7);
    check_latency(OP_BEQ, 6);
    check_latency(OP_J, 6);
    check_latency(6'b111111, 5);

    // Random instruction mix with random memory stalls.
    for (int n = 0; n < 80; n++) begin
      r = int'($urandom_range(0, 6));
      case (r)
        0: o = OP_RTYPE;
        1: o = OP_LB;
        2: o = OP_SB;
        3: o = OP_BEQ;
        4: o = OP_J;
        5: o = OP_ADDI;
        default: begin
          o = 6'($urandom);
          while (o inside {OP_RTYPE, OP_LB, OP_SB, OP_BEQ, OP_J, OP_ADDI}) o = 6'($urandom);
        end
      endcase
      add_instr(o, rb(), rb() ? 8'($urandom) : 8'h00, int'($urandom_range(0, 3)));
      run_to(0);
    end

    // Reset while SBWR is waiting: enables drop immediately, FETCH1 after the edge.
    add_instr(OP_SB, 1'b0, 8'h00, 4);
    run_to(5);
    q.delete();
    mem_ready = 1'b0; zero = 1'b0; op = OP_SB;
    @(negedge ph1);
    e = '0; e.memwrite = 1'b1; e.iord = 1'b1;
    check(e, 8);
    #1 reset = 1'b1;
    #1 check('0, 98);
    @(posedge ph1); #1;
    reset = 1'b0; mem_ready = 1'b1;
    @(negedge ph1);
    e = '0; e.memread = 1'b1; e.alusrcb = 2'b01; e.irwrite = 4'b0001; e.pcen = 1'b1;
    check(e, 0);
    @(posedge ph1); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore-style multicycle control FSM that sequences the 8-bit MIPS-subset datapath: PC, byte-wide instruction register, 8-entry register file, ALU and unified memory.
- Fetches each 32-bit instruction as four byte reads, decodes the opcode, then walks the execute, memory and writeback states.
- Drives every datapath select and enable line, including the register-file RegWrite.
- Stalls on memory via a ready handshake.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LB, 6'b100000, load byte
- OP_SB, 6'b101000, store byte
- OP_BEQ, 6'b000100, branch if equal
- OP_J, 6'b000010, jump
- OP_ADDI, 6'b001000, add immediate

Ports:
- ph1  in  1  clock; all state updates on posedge
- reset  in  1  reset, synchronous, active-high
- op  in  6  opcode from instruction register bits [31:26]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the access this cycle
- memread  out  1  memory read request
- memwrite  out  1  memory write request
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- irwrite  out  4  one-hot IR byte-lane enable
- pcen  out  1  PC load enable = pcwrite | (branch & zero)
- pcsource  out  2  00=ALU result, 01=ALUOut, 10=jump target
- alusrca  out  1  0=PC, 1=register A
- alusrcb  out  2  00=B, 01=const 1, 10=imm, 11=imm (branch offset)
- aluop  out  2  00=add, 01=sub, 10=funct-decoded
- regdst  out  1  write register: 0=rt, 1=rd
- memtoreg  out  1  write data: 0=ALUOut, 1=MDR
- regwrite  out  1  register-file write enable
- instr_done  out  1  one-cycle pulse in the final state of every instruction
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode

Behaviour:
- State register (4-bit) updates on posedge ph1. Outputs decode combinationally from state, plus the mem_ready, zero and op terms listed below.
- Reset:
  - reset=1 on a clock edge loads FETCH1, including mid-instruction; any partial instruction is abandoned.
  - While reset is high, all outputs are forced to 0, so no PC, IR or register write can occur.
- Unlisted outputs are 0 in each state.
- FETCH1..FETCH4:
  - memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00.
  - irwrite = 0001, 0010, 0100, 1000 respectively; pcwrite=1.
  - irwrite and pcwrite are gated by mem_ready; the state advances only when mem_ready=1, otherwise it holds with memread still high. Each byte is latched exactly once and PC increments exactly once per byte.
- DECODE: alusrcb=11, aluop=00. Next state by op:
  - LB/SB -> MEMADR; RTYPE -> RTYPEEX; BEQ -> BEQEX; J -> JEX; ADDI -> ADDIEX.
  - Any other op -> FETCH1 with illegal_op=1 and instr_done=1.
- MEMADR: alusrca=1, alusrcb=10. Next: LB -> LBRD, SB -> SBWR.
- LBRD: memread=1, iord=1. Holds until mem_ready, then -> LBWR.
- LBWR: regwrite=1, memtoreg=1, regdst=0, instr_done=1 -> FETCH1.
- SBWR: memwrite=1, iord=1. Holds until mem_ready; instr_done=1 only in the mem_ready cycle, then -> FETCH1.
- RTYPEEX: alusrca=1, aluop=10 -> RTYPEWR.
- RTYPEWR: regwrite=1, regdst=1, instr_done=1 -> FETCH1.
- BEQEX: alusrca=1, aluop=01, branch=1, pcsource=01, instr_done=1 -> FETCH1. pcen=zero.
- JEX: pcwrite=1, pcsource=10, instr_done=1 -> FETCH1.
- ADDIEX: alusrca=1, alusrcb=10 -> ADDIWR.
- ADDIWR: regwrite=1, regdst=0, instr_done=1 -> FETCH1.
- Unreachable state encodings -> FETCH1 next cycle, all outputs 0.
- Latency with mem_ready tied high:
  - 8 cycles: LB.
  - 7 cycles: SB, RTYPE, ADDI.
  - 6 cycles: BEQ, J.
  - 5 cycles: illegal opcode.
- op is sampled only in DECODE and MEMADR; it is stable there because the IR is fully loaded after FETCH4.
- The controller emits regwrite for rt/rd=0. Suppressing writes to register 0 is the register file's job.

Test Plan:
- Reset then release, mem_ready=1 -> outputs all 0 during reset; cycle 1 after release memread=1, irwrite=0001, pcen=1; irwrite walks 0010, 0100, 1000 in cycles 2-4.
- op=000000, mem_ready=1 -> DECODE, RTYPEEX (aluop=10), RTYPEWR (regwrite=1, regdst=1, instr_done=1); 7 cycles total, then FETCH1.
- op=100000, mem_ready low for 3 cycles in LBRD -> LBRD held 4 cycles with memread=1, iord=1; then LBWR with regwrite=1, memtoreg=1; regwrite pulses exactly once.
- op=000100, zero=1 then a repeat with zero=0 -> BEQEX pcen=1, pcsource=01 in the first case; pcen=0 in the second; both return to FETCH1 after 6 cycles.
- mem_ready=0 in FETCH2 for 2 cycles -> irwrite=0 and pcen=0 while stalled; exactly one 0010 pulse and one pcen pulse when mem_ready rises.
- op=111111 at DECODE -> illegal_op=1 and instr_done=1 for one cycle, then FETCH1. Separately, reset asserted in SBWR -> memwrite drops immediately, state is FETCH1 after the edge.
